// File: rtl/sc_regbackg_lane_bank_pkg.sv
// sc_regbackg_lane_bank_pkg
//   Shared constants and types for the Frogger background lane bank.
//   - DIR_LEFT / DIR_RIGHT : meaning of each dirLeft bit.
//   - DEFAULT_*            : board geometry of the playfield.
//   - PERIOD_SIM/BOARD     : scroll prescaler period for simulation vs. the 50 MHz board.
//   - lane_op_e            : what a lane does on the next clock edge.
package sc_regbackg_lane_bank_pkg;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_ROWS      = 16;
  localparam int DEFAULT_ADDRWIDTH = 4;

  localparam int PERIOD_SIM   = 4;
  localparam int PERIOD_BOARD = 25000000;

  // One lane's action for the coming edge, already resolved by priority.
  typedef enum logic [2:0] {
    LANE_HOLD,
    LANE_CLEAR,
    LANE_WRITE,
    LANE_ROTL,
    LANE_ROTR
  } lane_op_e;

endpackage

// File: rtl/sc_regbackg_lane_bank_prescaler.sv
// sc_regbackg_prescaler
//   Divides the clock down to the lane scroll rate.
//   Ports:
//     clk, reset   : system clock, synchronous active-high reset
//     clear_n      : active-low clear, restarts the count and kills any tick
//     run          : count enable; the counter freezes while low
//     scroll_evt   : combinational strobe, lanes rotate at this edge
//     tick         : registered pulse, high in the cycle after a scroll edge
module sc_regbackg_prescaler #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_n,
  input  logic run,
  output logic scroll_evt,
  output logic tick
);

  // A PERIOD of 1 still needs a one-bit counter; it simply stays at 0.
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // The scroll happens on the edge where the counter sits at its last value;
  // clear suppresses it so a cleared bank never rotates in the same cycle.
  always_comb begin
    scroll_evt = clear_n && run && (count_q == LAST);
    tick_d     = scroll_evt;
    count_d    = count_q;
    if (!clear_n) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sc_regbackg_lane_bank.sv
// sc_regbackg_lane_bank
//   Background register bank: ROWS lanes of DATAWIDTH bits, individually
//   writable, each optionally rotating one bit per prescaler tick.
//   Ports:
//     SC_RegBACKGLANE_CLOCK_50 / _RESET_InHigh : clock, synchronous reset
//     SC_RegBACKGLANE_clear_InLow              : zero all lanes and the prescaler
//     SC_RegBACKGLANE_write_InLow, _waddr_InBUS, _data_InBUS : lane write port
//     SC_RegBACKGLANE_raddr_InBUS, _data_OutBUS : combinational lane read
//     SC_RegBACKGLANE_run_InHigh               : prescaler enable
//     SC_RegBACKGLANE_scrollEn_InBUS / _dirLeft_InBUS : per-lane scroll control
//     SC_RegBACKGLANE_flat_OutBUS              : every lane, lane i at [i*W +: W]
//     SC_RegBACKGLANE_tick_OutHigh             : pulse when rotated lanes appear
module sc_regbackg_lane_bank
  import sc_regbackg_lane_bank_pkg::*;
#(
  parameter int RegBACKGLANE_DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int RegBACKGLANE_ROWS      = DEFAULT_ROWS,
  parameter int RegBACKGLANE_ADDRWIDTH = DEFAULT_ADDRWIDTH,
  parameter int RegBACKGLANE_PERIOD    = PERIOD_BOARD
) (
  input  logic                                              SC_RegBACKGLANE_CLOCK_50,
  input  logic                                              SC_RegBACKGLANE_RESET_InHigh,
  input  logic                                              SC_RegBACKGLANE_clear_InLow,
  input  logic                                              SC_RegBACKGLANE_write_InLow,
  input  logic [RegBACKGLANE_ADDRWIDTH-1:0]                 SC_RegBACKGLANE_waddr_InBUS,
  input  logic [RegBACKGLANE_DATAWIDTH-1:0]                 SC_RegBACKGLANE_data_InBUS,
  input  logic [RegBACKGLANE_ADDRWIDTH-1:0]                 SC_RegBACKGLANE_raddr_InBUS,
  input  logic                                              SC_RegBACKGLANE_run_InHigh,
  input  logic [RegBACKGLANE_ROWS-1:0]                      SC_RegBACKGLANE_scrollEn_InBUS,
  input  logic [RegBACKGLANE_ROWS-1:0]                      SC_RegBACKGLANE_dirLeft_InBUS,
  output logic [RegBACKGLANE_DATAWIDTH-1:0]                 SC_RegBACKGLANE_data_OutBUS,
  output logic [RegBACKGLANE_ROWS*RegBACKGLANE_DATAWIDTH-1:0] SC_RegBACKGLANE_flat_OutBUS,
  output logic                                              SC_RegBACKGLANE_tick_OutHigh
);

  localparam int W = RegBACKGLANE_DATAWIDTH;
  localparam int R = RegBACKGLANE_ROWS;
  localparam int A = RegBACKGLANE_ADDRWIDTH;

  logic           scroll_evt;
  logic [R*W-1:0] flat_bus;

  sc_regbackg_prescaler #(
    .PERIOD(RegBACKGLANE_PERIOD)
  ) u_prescaler (
    .clk       (SC_RegBACKGLANE_CLOCK_50),
    .reset     (SC_RegBACKGLANE_RESET_InHigh),
    .clear_n   (SC_RegBACKGLANE_clear_InLow),
    .run       (SC_RegBACKGLANE_run_InHigh),
    .scroll_evt(scroll_evt),
    .tick      (SC_RegBACKGLANE_tick_OutHigh)
  );

  for (genvar i = 0; i < R; i++) begin : g_lane
    localparam logic [A-1:0] LANE_ADDR = A'(i);

    logic [W-1:0] lane_q, lane_d;
    lane_op_e     op;

    // Priority clear > write > scroll. An out-of-range waddr never matches
    // any lane, so such a write falls through to scroll/hold everywhere.
    always_comb begin
      op = LANE_HOLD;
      if (!SC_RegBACKGLANE_clear_InLow) begin
        op = LANE_CLEAR;
      end else if (!SC_RegBACKGLANE_write_InLow && (SC_RegBACKGLANE_waddr_InBUS == LANE_ADDR)) begin
        op = LANE_WRITE;
      end else if (scroll_evt && SC_RegBACKGLANE_scrollEn_InBUS[i]) begin
        op = (SC_RegBACKGLANE_dirLeft_InBUS[i] == DIR_LEFT) ? LANE_ROTL : LANE_ROTR;
      end
    end

    always_comb begin
      lane_d = lane_q;
      case (op)
        LANE_CLEAR: lane_d = '0;
        LANE_WRITE: lane_d = SC_RegBACKGLANE_data_InBUS;
        LANE_ROTL:  lane_d = {lane_q[W-2:0], lane_q[W-1]};
        LANE_ROTR:  lane_d = {lane_q[0], lane_q[W-1:1]};
        default:    lane_d = lane_q;
      endcase
    end

    always_ff @(posedge SC_RegBACKGLANE_CLOCK_50) begin
      if (SC_RegBACKGLANE_RESET_InHigh) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign flat_bus[i*W +: W] = lane_q;
  end

  // Read mux shows the stored value only; an address beyond the last lane reads 0.
  always_comb begin
    SC_RegBACKGLANE_data_OutBUS = '0;
    for (int r = 0; r < R; r++) begin
      if (SC_RegBACKGLANE_raddr_InBUS == A'(r)) begin
        SC_RegBACKGLANE_data_OutBUS = flat_bus[r*W +: W];
      end
    end
  end

  assign SC_RegBACKGLANE_flat_OutBUS = flat_bus;

endmodule

// File: tb/tb_sc_regbackg_lane_bank.sv
// tb_sc_regbackg_lane_bank
//   Drives the lane bank with directed scenarios plus random traffic and
//   compares it against a lane-level behavioural model.
module tb_sc_regbackg_lane_bank;

  localparam int W      = 8;
  localparam int ROWS   = 4;
  localparam int A      = 2;
  localparam int PERIOD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_n;
  logic              wr_n;
  logic [A-1:0]      waddr;
  logic [W-1:0]      wdata;
  logic [A-1:0]      raddr;
  logic              run;
  logic [ROWS-1:0]   scroll_en;
  logic [ROWS-1:0]   dir_left;
  logic [W-1:0]      rdata;
  logic [ROWS*W-1:0] flat;
  logic              tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: lane contents, prescaler count, tick seen after the last edge.
  logic [W-1:0] m_lane [ROWS];
  int           m_cnt;
  logic         m_tick;

  sc_regbackg_lane_bank #(
    .RegBACKGLANE_DATAWIDTH(W),
    .RegBACKGLANE_ROWS     (ROWS),
    .RegBACKGLANE_ADDRWIDTH(A),
    .RegBACKGLANE_PERIOD   (PERIOD)
  ) dut (
    .SC_RegBACKGLANE_CLOCK_50      (clk),
    .SC_RegBACKGLANE_RESET_InHigh  (rst),
    .SC_RegBACKGLANE_clear_InLow   (clr_n),
    .SC_RegBACKGLANE_write_InLow   (wr_n),
    .SC_RegBACKGLANE_waddr_InBUS   (waddr),
    .SC_RegBACKGLANE_data_InBUS    (wdata),
    .SC_RegBACKGLANE_raddr_InBUS   (raddr),
    .SC_RegBACKGLANE_run_InHigh    (run),
    .SC_RegBACKGLANE_scrollEn_InBUS(scroll_en),
    .SC_RegBACKGLANE_dirLeft_InBUS (dir_left),
    .SC_RegBACKGLANE_data_OutBUS   (rdata),
    .SC_RegBACKGLANE_flat_OutBUS   (flat),
    .SC_RegBACKGLANE_tick_OutHigh  (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rot_left(input logic [W-1:0] x);
    return W'((int'(x) * 2) % (1 << W) + int'(x) / (1 << (W - 1)));
  endfunction

  function automatic logic [W-1:0] rot_right(input logic [W-1:0] x);
    return W'(int'(x) / 2 + (int'(x) % 2) * (1 << (W - 1)));
  endfunction

  function automatic logic [ROWS*W-1:0] model_flat();
    logic [ROWS*W-1:0] f;
    f = '0;
    for (int i = 0; i < ROWS; i++) f[i*W +: W] = m_lane[i];
    return f;
  endfunction

  function automatic logic [W-1:0] model_read(input logic [A-1:0] a);
    return (int'(a) < ROWS) ? m_lane[a] : '0;
  endfunction

  // Apply one clock edge worth of the bank's rules to the model.
  task automatic model_edge();
    logic evt;
    if (rst || !clr_n) begin
      for (int i = 0; i < ROWS; i++) m_lane[i] = '0;
      m_cnt  = 0;
      m_tick = 1'b0;
    end else begin
      evt = run && (m_cnt == PERIOD - 1);
      if (run) m_cnt = (m_cnt + 1) % PERIOD;
      for (int i = 0; i < ROWS; i++) begin
        if (!wr_n && int'(waddr) == i) m_lane[i] = wdata;
        else if (evt && scroll_en[i]) m_lane[i] = dir_left[i] ? rot_left(m_lane[i]) : rot_right(m_lane[i]);
      end
      m_tick = evt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic c_n, input logic w_n,
                               input logic [A-1:0] wa, input logic [W-1:0] wd, input logic rn);
    rst   = r;
    clr_n = c_n;
    wr_n  = w_n;
    waddr = wa;
    wdata = wd;
    run   = rn;
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
  endtask

  task automatic write_lane(input logic [A-1:0] a, input logic [W-1:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    scroll_en = '0;
    dir_left  = '0;
    raddr     = '0;
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0);
    step();
    step();
    n_checks++;
    if (flat !== '0) begin n_fail++; $display("[TB] FAIL reset_flat: got %h expected 0", flat); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
    step();
    for (int a = 0; a < ROWS; a++) begin
      raddr = A'(a);
      #1;
      n_checks++;
      if (rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_read%0d: got %h expected 0", a, rdata); end
    end
  endtask

  task automatic test_write_read();
    raddr = 2'd2;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'hA5, 1'b0);
    #1;
    n_checks++;
    if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL no_bypass: got %h expected 00", rdata); end
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
    #1;
    n_checks++;
    if (rdata !== 8'hA5) begin n_fail++; $display("[TB] FAIL write_read: got %h expected a5", rdata); end
    n_checks++;
    if (flat !== 32'h00A5_0000 || flat !== model_flat())
      begin n_fail++; $display("[TB] FAIL write_flat: got %h expected 00a50000", flat); end
  endtask

  task automatic test_mixed_scroll();
    int ticks;
    do_reset();
    write_lane(2'd0, 8'h81);
    write_lane(2'd1, 8'h81);
    write_lane(2'd2, 8'h5A);
    write_lane(2'd3, 8'h3C);
    scroll_en = 4'b0011;
    dir_left  = 4'b0001;
    run       = 1'b1;
    ticks     = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (tick === 1'b1) ticks++;
      n_checks++;
      if (tick !== m_tick) begin n_fail++; $display("[TB] FAIL scroll_tick c%0d: got %b expected %b", c, tick, m_tick); end
      if (c == 4) begin
        n_checks++;
        if (flat !== 32'h3C5A_C003 || flat !== model_flat())
          begin n_fail++; $display("[TB] FAIL scroll_one: got %h expected 3c5ac003", flat); end
      end
    end
    n_checks++;
    if (ticks != 1) begin n_fail++; $display("[TB] FAIL tick_width: got %0d expected 1", ticks); end
    for (int c = 0; c < 27; c++) step();
    n_checks++;
    if (flat !== 32'h3C5A_8181 || flat !== model_flat())
      begin n_fail++; $display("[TB] FAIL scroll_full_turn: got %h expected 3c5a8181", flat); end
  endtask

  task automatic test_pause();
    do_reset();
    write_lane(2'd0, 8'h01);
    scroll_en = 4'b0001;
    dir_left  = 4'b0001;
    run       = 1'b1;
    step();
    step();
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (tick !== 1'b0 || flat !== 32'h0000_0001)
        begin n_fail++; $display("[TB] FAIL paused c%0d: got tick %b flat %h expected 0 00000001", c, tick, flat); end
    end
    run = 1'b1;
    step();
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("[TB] FAIL resume_early: got %b expected 0", tick); end
    step();
    n_checks++;
    if (tick !== 1'b1 || flat !== 32'h0000_0002 || flat !== model_flat())
      begin n_fail++; $display("[TB] FAIL resume_tick: got tick %b flat %h expected 1 00000002", tick, flat); end
  endtask

  task automatic test_collision();
    do_reset();
    write_lane(2'd0, 8'h11);
    write_lane(2'd1, 8'h81);
    scroll_en = 4'b0011;
    dir_left  = 4'b0011;
    run       = 1'b1;
    for (int c = 0; c < 3; c++) step();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'h0F, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
    n_checks++;
    if (tick !== 1'b1 || flat !== 32'h0000_030F || flat !== model_flat())
      begin n_fail++; $display("[TB] FAIL collision: got tick %b flat %h expected 1 0000030f", tick, flat); end
  endtask

  task automatic test_clear_reset();
    do_reset();
    write_lane(2'd3, 8'h77);
    write_lane(2'd1, 8'h12);
    scroll_en = 4'b1111;
    dir_left  = 4'b0000;
    run       = 1'b1;
    for (int c = 0; c < 3; c++) step();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1);
    step();
    n_checks++;
    if (flat !== '0 || tick !== 1'b0)
      begin n_fail++; $display("[TB] FAIL clear_wins: got tick %b flat %h expected 0 00000000", tick, flat); end
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (tick !== (c == 4)) begin n_fail++; $display("[TB] FAIL clear_restart c%0d: got %b expected %b", c, tick, c == 4); end
    end
    write_lane(2'd2, 8'hAA);
    run = 1'b1;
    for (int c = 0; c < 3; c++) step();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h55, 1'b1);
    step();
    n_checks++;
    if (flat !== '0 || tick !== 1'b0)
      begin n_fail++; $display("[TB] FAIL reset_mid: got tick %b flat %h expected 0 00000000", tick, flat); end
    applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (tick !== (c == 4)) begin n_fail++; $display("[TB] FAIL reset_restart c%0d: got %b expected %b", c, tick, c == 4); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom % 60) == 0, ($urandom % 30) != 0, ($urandom % 3) != 0,
                    A'($urandom), W'($urandom), ($urandom % 5) != 0);
      raddr     = A'($urandom);
      scroll_en = ROWS'($urandom);
      dir_left  = ROWS'($urandom);
      #1;
      n_checks++;
      if (rdata !== model_read(raddr))
        begin n_fail++; $display("[TB] FAIL rand_read c%0d: got %h expected %h", c, rdata, model_read(raddr)); end
      step();
      n_checks++;
      if (flat !== model_flat() || tick !== m_tick)
        begin n_fail++; $display("[TB] FAIL rand_state c%0d: got %h/%b expected %h/%b", c, flat, tick, model_flat(), m_tick); end
    end
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) m_lane[i] = '0;
    m_cnt  = 0;
    m_tick = 1'b0;
    test_reset();
    test_write_read();
    test_mixed_scroll();
    test_pause();
    test_collision();
    test_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_regbackg_lane_bank.md
Name: sc_regbackg_lane_bank

Overview:
- Multi-row background register bank for the Frogger playfield.
- Holds ROWS lane patterns of DATAWIDTH bits each.
- Each lane can be written individually, and lanes auto-scroll by rotating their bits on a programmable prescaler tick.
- Sits between the level/game controller, which writes lane patterns, and the matrix display path, which reads the flattened bus; it replaces a bank of single-row background registers.

Parameters:
- RegBACKGLANE_DATAWIDTH, 8, bits per lane (column count); must be >= 2.
- RegBACKGLANE_ROWS, 16, number of lanes.
- RegBACKGLANE_ADDRWIDTH, 4, lane address width; must satisfy 2^ADDRWIDTH >= ROWS.
- RegBACKGLANE_PERIOD, 25000000, clock cycles per scroll tick; must be >= 1.

Ports:
- SC_RegBACKGLANE_CLOCK_50  in  1  system clock, all logic on the rising edge.
- SC_RegBACKGLANE_RESET_InHigh  in  1  synchronous active-high reset.
- SC_RegBACKGLANE_clear_InLow  in  1  active-low synchronous clear of all lanes and the prescaler.
- SC_RegBACKGLANE_write_InLow  in  1  active-low write strobe.
- SC_RegBACKGLANE_waddr_InBUS  in  ADDRWIDTH  lane written.
- SC_RegBACKGLANE_data_InBUS  in  DATAWIDTH  write data.
- SC_RegBACKGLANE_raddr_InBUS  in  ADDRWIDTH  lane read.
- SC_RegBACKGLANE_run_InHigh  in  1  prescaler enable; 0 pauses scrolling.
- SC_RegBACKGLANE_scrollEn_InBUS  in  ROWS  per-lane scroll enable.
- SC_RegBACKGLANE_dirLeft_InBUS  in  ROWS  per-lane direction; 1 = rotate left, 0 = rotate right.
- SC_RegBACKGLANE_data_OutBUS  out  DATAWIDTH  lane at raddr (combinational read).
- SC_RegBACKGLANE_flat_OutBUS  out  ROWS*DATAWIDTH  all lanes; lane i occupies bits [i*W+W-1 : i*W].
- SC_RegBACKGLANE_tick_OutHigh  out  1  registered one-cycle pulse marking a scroll.

Behaviour:
- Reset is synchronous and active-high. One clock; reset is sampled only on the SC_RegBACKGLANE_CLOCK_50 rising edge.
- Reset state: all lanes 0, prescaler counter 0, tick_OutHigh 0, data_OutBUS 0, flat_OutBUS 0.
- Priority per edge, highest first: reset > clear > write > scroll.
  - Clear zeroes every lane and the counter, and forces tick to 0. Write and scroll are ignored that cycle.
- Prescaler:
  - If run=1: when counter==PERIOD-1, counter wraps to 0 and a scroll event occurs at this edge; otherwise the counter increments.
  - If run=0: the counter holds and no scroll occurs.
  - PERIOD=1: a scroll occurs every cycle while run=1.
- Scroll event: each lane i with scrollEn[i]=1 rotates by one bit at the same edge; lanes with scrollEn[i]=0 hold.
  - Left rotate: {d[W-2:0], d[W-1]}.
  - Right rotate: {d[0], d[W-1:1]}.
- tick_OutHigh is 1 in the cycle after a scroll edge, i.e. the cycle in which the rotated values are first visible. Otherwise it is 0.
- Write: write_InLow=0 loads data_InBUS into lane waddr at the next edge, with 1-cycle latency to the outputs.
  - A write to a lane in the same cycle as a scroll event: the written value wins for that lane, unrotated. Other lanes still scroll.
  - Write with waddr >= ROWS is ignored; no lane changes.
- Read: data_OutBUS = lane[raddr], combinational. It returns 0 when raddr >= ROWS. No read-during-write bypass: the old value is shown until the edge.
- Rotation never changes the population count of a lane. No saturation or overflow conditions exist beyond the counter wrap.
- Asserting reset mid-scroll or mid-write discards the operation; the state returns to the reset values at that edge.

Decomposition:
- Shared package/include:
  - lane direction constants (DIR_LEFT=1, DIR_RIGHT=0);
  - default DATAWIDTH/ROWS;
  - the PERIOD value for simulation (e.g. 4) vs. board (25000000).
- One natural sub-module: sc_regbackg_prescaler. It holds the counter, run/clear handling and the registered tick, and outputs a scroll-event strobe plus tick.
- Lane storage and rotate/write muxing stay in the top level as a generate loop over ROWS.

Test Plan:
Parameters for all scenarios: W=8, ROWS=4, ADDRWIDTH=2, PERIOD=4.
1. Reset then idle. Assert reset for 2 cycles with run=0 → flat_OutBUS=0, tick=0, data_OutBUS=0 for every raddr.
2. Write and read. Write 8'hA5 to lane 2; set raddr=2 → data_OutBUS=8'hA5 one cycle after the write edge; other lanes remain 0.
3. Mixed scroll. Lane0=8'h81 with dirLeft=1, lane1=8'h81 with dirLeft=0, scrollEn=4'b0011, run=1.
   - After 4 cycles: lane0=8'h03, lane1=8'hC0, lanes 2-3 unchanged, tick high exactly one cycle.
   - After 8 rotations: both lanes are back to 8'h81.
4. Pause. Drop run after 2 counted cycles, hold 10 cycles, then raise run → first tick appears 2 run-cycles later; no lane changes while paused.
5. Write/scroll collision. Write 8'h0F to lane 0 on the scroll edge with scrollEn[0]=1 → lane0=8'h0F unrotated; lane1 still rotates.
6. Clear vs. write, and reset mid-operation.
   - Assert clear and write to lane 3 in the same cycle → all lanes 0 and counter restarts (next tick 4 cycles later).
   - Assert reset mid-count → same zero state, with tick=0.
